ternary_sampler: RTL and testbench
==================================

TERNARY_SAMPLER -- requirements
Module: ternary_sampler

Interface
REQ-001 Parameter: N, default 700, number of ternary coefficients per polynomial.
REQ-002 Parameter: IW, default 10, index width; SHALL satisfy 2^IW >= N.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to sample one polynomial.
REQ-006 in_data  input  8  random byte from the coin source.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  sampler accepts in_data this cycle.
REQ-009 coef  output  2  coefficient, in_data mod 3, range {0,1,2}.
REQ-010 coef_valid  output  1  coef, coef_idx, coef_last valid.
REQ-011 coef_ready  input  1  downstream accepts coef this cycle.
REQ-012 coef_idx  output  IW  coefficient index, 0..N-1.
REQ-013 coef_last  output  1  high with coef_idx == N-1.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse after the last coefficient handshake.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE -> RUN on start; accepted-byte counter cnt cleared to 0 on this transition.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 Input handshake: byte accepted when in_valid && in_ready.
REQ-020 in_ready = (state == RUN) && (!coef_valid || coef_ready); combinational; no dependency on in_valid.
REQ-021 Accepted byte b loads the output register next edge: coef = b mod 3, coef_idx = cnt, coef_last = (cnt == N-1), coef_valid = 1; cnt increments.
REQ-022 Latency: one cycle from byte acceptance to coef_valid.
REQ-023 mod 3 SHALL be exact for all 256 byte values; e.g. 0->0, 1->1, 2->2, 3->0, 254->2, 255->0.
REQ-024 Output register holds coef, coef_idx, coef_last stable while coef_valid && !coef_ready.
REQ-025 coef_valid clears on the handshake edge unless a new byte is accepted in the same cycle; in that case it stays high and the register loads the new value.
REQ-026 Sustained throughput: one coefficient per cycle when in_valid and coef_ready are held high.
REQ-027 RUN -> DRAIN on acceptance of byte N-1; in_ready SHALL be 0 from the next cycle on.
REQ-028 DRAIN -> DONE on handshake of the coef with coef_last = 1.
REQ-029 DONE lasts one cycle with done = 1, then -> IDLE.
REQ-030 Exactly N bytes consumed and N coefficients emitted per start; no bytes consumed in IDLE, DRAIN, DONE.
REQ-031 in_valid low in RUN: no state change; the pending output register is unaffected.

Reset
REQ-032 rst SHALL take priority over all inputs, including mid-operation.
REQ-033 Reset values: state IDLE, cnt 0, coef 0, coef_idx 0, coef_last 0, coef_valid 0, in_ready 0, busy 0, done 0.
REQ-034 A partially emitted polynomial is discarded on rst; the next start restarts at index 0.

Verification
REQ-035 Basic: N=4, start, bytes 7,8,9,255 with coef_ready=1 -> coef 1,2,0,0; idx 0..3; coef_last only at idx 3; done one cycle after the idx-3 handshake.
REQ-036 Exhaustive mod: N=256, bytes 0..255 in order -> coef = b mod 3 for every b; done asserted exactly once.
REQ-037 Backpressure: coef_ready low for 3 cycles with coef_valid high -> coef/idx stable, in_ready 0, no byte lost or duplicated.
REQ-038 Throughput: in_valid=1 and coef_ready=1 throughout, N=700 -> 700 consecutive coef_valid cycles, in_ready 0 after the 700th accept.
REQ-039 Reset mid-operation: rst at idx 300 -> all outputs at reset values next cycle; a following start emits idx 0 from the first new byte.
REQ-040 Stray start: start pulses during RUN and DRAIN -> ignored; count remains exactly N.

Source files
------------

// File: rtl/ternary_sampler_if.sv
// Coin-byte input stream, indexed coefficient output stream and status for the ternary sampler.
// slave is the sampler's view; master is the driver/consumer view.
interface ternary_sampler_if #(
  parameter int IW = 10
) ();
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    coef;
  logic          coef_valid;
  logic          coef_ready;
  logic [IW-1:0] coef_idx;
  logic          coef_last;
  logic          busy;
  logic          done;

  modport slave (
    input  start, in_data, in_valid, coef_ready,
    output in_ready, coef, coef_valid, coef_idx, coef_last, busy, done
  );

  modport master (
    output start, in_data, in_valid, coef_ready,
    input  in_ready, coef, coef_valid, coef_idx, coef_last, busy, done
  );
endinterface

// File: rtl/ternary_sampler.sv
// Maps each accepted coin byte to (byte mod 3) and emits N indexed coefficients per start.
// One cycle byte->coef; single output register, so in_ready drops while it holds an unaccepted coef.
module ternary_sampler #(
  parameter int N  = 700,
  parameter int IW = 10
) (
  input logic              clk,
  input logic              rst,
  ternary_sampler_if.slave s
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] cnt;
  logic [1:0]    coef_q;
  logic [IW-1:0] idx_q;
  logic          last_q;
  logic          valid_q;
  logic          done_q;
  logic          in_ready_w;
  logic          accept;
  logic          handoff;

  function automatic logic [1:0] mod3(input logic [7:0] b);
    logic [7:0] r;
    r = b % 8'd3;
    return r[1:0];
  endfunction

  // The output slot is free when empty or being drained this cycle, which keeps one coef per cycle.
  assign in_ready_w = (state == RUN) && (!valid_q || s.coef_ready);
  assign accept     = s.in_valid && in_ready_w;
  assign handoff    = valid_q && s.coef_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      coef_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        coef_q  <= mod3(s.in_data);
        idx_q   <= cnt;
        last_q  <= (cnt == LAST_IDX);
        valid_q <= 1'b1;
        cnt     <= cnt + IW'(1);
      end else if (handoff) begin
        valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s.start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (accept && (cnt == LAST_IDX)) state <= DRAIN;
        end
        DRAIN: begin
          if (handoff && last_q) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign s.in_ready   = in_ready_w;
  assign s.coef       = coef_q;
  assign s.coef_valid = valid_q;
  assign s.coef_idx   = idx_q;
  assign s.coef_last  = last_q;
  assign s.busy       = (state == RUN) || (state == DRAIN);
  assign s.done       = done_q;
endmodule

// File: tb/tb_ternary_sampler.sv
// Directed bench for ternary_sampler: three instances (N=4, 256, 700) exercised in sequence.
module tb_ternary_sampler;
  localparam int IW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          st  [3];
  logic          iv  [3];
  logic          cr  [3];
  logic [7:0]    din [3];
  logic          ir  [3];
  logic          cv  [3];
  logic          cl  [3];
  logic          bz  [3];
  logic          dn  [3];
  logic [1:0]    co  [3];
  logic [IW-1:0] ix  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN = (g == 0) ? 4 : (g == 1) ? 256 : 700;
    ternary_sampler_if #(.IW(IW)) sif ();
    assign sif.start      = st[g];
    assign sif.in_data    = din[g];
    assign sif.in_valid   = iv[g];
    assign sif.coef_ready = cr[g];
    assign ir[g] = sif.in_ready;
    assign cv[g] = sif.coef_valid;
    assign cl[g] = sif.coef_last;
    assign bz[g] = sif.busy;
    assign dn[g] = sif.done;
    assign co[g] = sif.coef;
    assign ix[g] = sif.coef_idx;
    ternary_sampler #(.N(NN), .IW(IW)) dut (.clk(clk), .rst(rst), .s(sif));
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int k, input string tag);
    chk({tag, "_coef_valid"}, 32'(cv[k]), 0);
    chk({tag, "_coef"},       32'(co[k]), 0);
    chk({tag, "_coef_idx"},   32'(ix[k]), 0);
    chk({tag, "_coef_last"},  32'(cl[k]), 0);
    chk({tag, "_in_ready"},   32'(ir[k]), 0);
    chk({tag, "_busy"},       32'(bz[k]), 0);
    chk({tag, "_done"},       32'(dn[k]), 0);
  endtask

  // One polynomial on instance k. Expected residues come from a hand table (N=4) or from a
  // residue counter that steps 0,1,2 with the byte value and restarts at byte 0.
  task automatic run_poly(input int k, input int n, input int stall_at, input bit stray,
                          input bit gaps, input int abort_at);
    logic [1:0]    expq [$];
    logic [7:0]    tb4 [4];
    logic [1:0]    te4 [4];
    logic [1:0]    r;
    logic [1:0]    h_co;
    logic [IW-1:0] h_ix;
    logic          h_cl;
    logic [1:0]    e;
    bit            acc, hs, stalled, aborted;
    int            sent, got, cyc, dones, vcyc;
    tb4 = '{8'd7, 8'd8, 8'd9, 8'd255};
    te4 = '{2'd1, 2'd2, 2'd0, 2'd0};
    r = 2'd0; sent = 0; got = 0; cyc = 0; dones = 0; vcyc = 0;
    stalled = 1'b0; aborted = 1'b0;

    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    chk("busy_after_start", 32'(bz[k]), 1);
    cr[k]  = 1'b1;
    din[k] = (n == 4) ? tb4[0] : 8'd0;

    while (dones == 0 && !aborted && cyc < 5000) begin
      cyc++;
      iv[k] = !(gaps && (cyc % 5 == 2));
      st[k] = stray && (cyc % 7 == 3);
      if (!stalled && stall_at >= 0 && cv[k] && ix[k] == IW'(stall_at)) begin
        h_co = co[k]; h_ix = ix[k];
        cr[k] = 1'b0;
        stalled = 1'b1;
        st[k] = stray;
        repeat (3) begin
          #1 chk("stall_in_ready", 32'(ir[k]), 0);
          tick();
          chk("stall_coef",  32'(co[k]), 32'(h_co));
          chk("stall_idx",   32'(ix[k]), 32'(h_ix));
          chk("stall_valid", 32'(cv[k]), 1);
        end
        cr[k] = 1'b1;
        st[k] = 1'b0;
      end
      if (abort_at >= 0 && cv[k] && ix[k] == IW'(abort_at)) begin
        rst = 1'b1;
        tick();
        chk_reset(k, "abort");
        rst = 1'b0;
        iv[k] = 1'b0;
        st[k] = 1'b0;
        aborted = 1'b1;
      end else begin
        #1;
        acc = iv[k] && ir[k];
        hs  = cv[k] && cr[k];
        h_co = co[k]; h_ix = ix[k]; h_cl = cl[k];
        if (cv[k]) vcyc++;
        @(posedge clk);
        #1;
        if (acc) begin
          expq.push_back((n == 4) ? te4[sent % 4] : r);
          chk("latency_valid", 32'(cv[k]), 1);
          chk("latency_idx",   32'(ix[k]), sent);
          sent++;
          r = (din[k] == 8'd255 || r == 2'd2) ? 2'd0 : r + 2'd1;
          din[k] = (n == 4) ? tb4[sent % 4] : din[k] + 8'd1;
          if (sent == n) begin
            #1 chk("in_ready_after_last", 32'(ir[k]), 0);
          end
        end
        if (hs) begin
          chk("no_spurious_coef", 32'(expq.size() > 0), 1);
          e = (expq.size() > 0) ? expq.pop_front() : 2'd3;
          chk("coef",      32'(h_co), 32'(e));
          chk("coef_idx",  32'(h_ix), got);
          chk("coef_last", 32'(h_cl), 32'(got == n - 1));
          got++;
          if (got == n) chk("done_after_last_hs", 32'(dn[k]), 1);
        end
        if (dn[k]) begin
          dones++;
          chk("done_coef_count", got, n);
          chk("done_byte_count", sent, n);
        end
      end
    end
    st[k] = 1'b0;
    iv[k] = 1'b0;
    if (!aborted) begin
      chk("done_seen", dones, 1);
      if (stall_at < 0 && !gaps) begin
        chk("throughput_cycles", cyc, n + 1);
        chk("valid_cycles", vcyc, n);
      end
      tick();
      chk("done_one_cycle", 32'(dn[k]), 0);
      chk("idle_busy",      32'(bz[k]), 0);
      chk("idle_valid",     32'(cv[k]), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; iv[k] = 1'b0; cr[k] = 1'b0; din[k] = 8'd0;
    end
    tick();
    tick();
    chk_reset(0, "rst_n4");
    chk_reset(1, "rst_n256");
    chk_reset(2, "rst_n700");

    st[0] = 1'b1;
    tick();
    chk("rst_over_start", 32'(bz[0]), 0);
    st[0] = 1'b0;
    rst = 1'b0;

    iv[0] = 1'b1; din[0] = 8'd5; cr[0] = 1'b1;
    #1 chk("idle_in_ready", 32'(ir[0]), 0);
    tick();
    chk("idle_no_accept", 32'(cv[0]), 0);
    iv[0] = 1'b0;

    run_poly(0, 4, -1, 1'b0, 1'b0, -1);
    run_poly(0, 4, 1, 1'b1, 1'b0, -1);
    run_poly(0, 4, 3, 1'b1, 1'b0, -1);
    run_poly(1, 256, 100, 1'b0, 1'b1, -1);
    run_poly(2, 700, -1, 1'b0, 1'b0, -1);
    run_poly(2, 700, -1, 1'b0, 1'b0, 300);
    run_poly(2, 700, -1, 1'b1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
